fp_normalize: RTL and testbench



---
 rtl/fpu_pkg.sv | 15 +
 rtl/fp_normalize_lzc48.sv | 10 +
 rtl/fp_normalize.sv | 126 ++++++++++++
 tb/tb_fp_normalize.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU widths, rounding-mode encodings and the normalized significand word type.
package fpu_pkg;
  localparam int SIG_W   = 24;
  localparam int PROD_W  = 48;
  localparam int EXP_W   = 9;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  typedef enum logic [1:0] {
    to_Near = 2'b00,
    to_Zero = 2'b01,
    to_Pinf = 2'b10,
    to_Ninf = 2'b11
  } rnd_mode_t;
  typedef logic [SIG_W:0] after_norm_t;
endpackage

// File: rtl/fp_normalize_lzc48.sv
// lzc48: combinational leading-zero counter, counts from bit 47 down (48 when all zero).
module lzc48 (
  input  logic [47:0] i_x,
  output logic [5:0]  o_cnt
);
  always_comb begin
    o_cnt = 6'd48;
    for (int i = 0; i < 48; i++) if (i_x[i]) o_cnt = 6'(47 - i);
  end
endmodule

// File: rtl/fp_normalize.sv
// fp_normalize: 3-stage post-multiply normalizer with valid/ready back-pressure.
// Define FP_NORM_SUBNORMAL_EN for gradual underflow; otherwise underflowing results flush to zero.
module fp_normalize
  import fpu_pkg::*;
#(
  parameter int MAX_RSHIFT = 26
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] M_in,
  input  logic [9:0]        E_in,
  input  logic              S_in,
  output logic              out_valid,
  input  logic              out_ready,
  output after_norm_t       After_norm,
  output logic              T,
  output logic              Sz,
  output logic [EXP_W-1:0]  Ez,
  output logic              exp_ovf,
  output logic              underflow
);
  logic w_en, w_st, w_rs, w_uf, w_t;
  logic r1_v, r1_s, r2_v, r2_s, r2_st, r2_nz;
  logic [PROD_W-1:0] r1_m;
  logic [PROD_W-2:0] w_n, r2_n;
  logic signed [11:0] r1_e, r2_e, w_e, w_em1;
  logic [5:0] w_lz, w_sl;
  after_norm_t w_an;
`ifdef FP_NORM_SUBNORMAL_EN
  logic signed [11:0] w_srf;
  logic [5:0] w_sr;
`endif

  if (MAX_RSHIFT < 1 || MAX_RSHIFT > 47) begin : g_bad_cap
    $error("fp_normalize: MAX_RSHIFT must be in 1..47");
  end

  assign w_en = !out_valid | out_ready;
  assign in_ready = w_en;

  // A forced 1 below bit 46 bounds the count at 47 for an all-zero fraction.
  lzc48 u_lzc (.i_x({r1_m[PROD_W-2:0], 1'b1}), .o_cnt(w_lz));

  assign w_em1 = r1_e - 12'sd1;
  assign w_sl = (w_em1 < $signed({6'd0, w_lz})) ? w_em1[5:0] : w_lz;

  always_comb begin
    w_n = r1_m[PROD_W-2:0];
    w_e = r1_e;
    w_st = 1'b0;
    w_rs = 1'b0;
    if (r1_m == '0) begin
      w_n = '0;
      w_e = '0;
    end else if (r1_m[PROD_W-1]) begin
      w_n = r1_m[PROD_W-1:1];
      w_st = r1_m[0];
      w_e = r1_e + 12'sd1;
      w_rs = (w_e <= 12'sd0);
    end else if (r1_e >= 12'sd1) begin
      w_n = r1_m[PROD_W-2:0] << w_sl;
      w_e = (w_sl < w_lz) ? '0 : r1_e - $signed({6'd0, w_sl});
    end else
      w_rs = 1'b1;
`ifdef FP_NORM_SUBNORMAL_EN
    w_srf = 12'sd1 - w_e;
    w_sr = (w_srf > $signed(12'(MAX_RSHIFT))) ? 6'(MAX_RSHIFT) : w_srf[5:0];
    if (w_rs) begin
      w_st = w_st | (|(w_n & ~({(PROD_W-1){1'b1}} << w_sr)));
      w_n = w_n >> w_sr;
    end
`endif
    if (w_rs) w_e = '0;
  end

  assign w_uf = (r2_e == '0) & r2_nz;
`ifdef FP_NORM_SUBNORMAL_EN
  assign w_an = r2_n[46:22];
  assign w_t  = (|r2_n[21:0]) | r2_st;
`else
  assign w_an = w_uf ? '0 : r2_n[46:22];
  assign w_t  = !w_uf & ((|r2_n[21:0]) | r2_st);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r1_v <= 1'b0;
      r1_m <= '0;
      r1_e <= '0;
      r1_s <= 1'b0;
      r2_v <= 1'b0;
      r2_n <= '0;
      r2_e <= '0;
      r2_st <= 1'b0;
      r2_nz <= 1'b0;
      r2_s <= 1'b0;
      out_valid <= 1'b0;
      After_norm <= '0;
      T <= 1'b0;
      Sz <= 1'b0;
      Ez <= '0;
      exp_ovf <= 1'b0;
      underflow <= 1'b0;
    end else if (w_en) begin
      r1_v <= in_valid;
      r1_m <= M_in;
      r1_e <= {{2{E_in[9]}}, E_in};
      r1_s <= S_in;
      r2_v <= r1_v;
      r2_n <= w_n;
      r2_e <= w_e;
      r2_st <= w_st;
      r2_nz <= |r1_m;
      r2_s <= r1_s;
      out_valid <= r2_v;
      After_norm <= w_an;
      T <= w_t;
      Sz <= r2_s;
      Ez <= r2_e[EXP_W-1:0];
      exp_ovf <= (r2_e >= $signed(12'(EXP_MAX)));
      underflow <= w_uf;
    end
  end
endmodule

// File: tb/tb_fp_normalize.sv
// tb_fp_normalize: scoreboard bench for fp_normalize covering directed vectors, underflow
// boundaries, random words, back-pressure and mid-flight reset.
module tb_fp_normalize;
  typedef struct {
    logic [24:0] an;
    logic        t;
    logic        s;
    logic [8:0]  ez;
    logic        ovf;
    logic        uf;
    int          cyc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0, RST = 1'b1, in_valid = 1'b0, out_ready = 1'b1, S_in = 1'b0;
  logic [47:0] M_in = '0;
  logic [9:0]  E_in = '0;
  logic        in_ready, out_valid, T, Sz, exp_ovf, underflow;
  logic [24:0] After_norm;
  logic [8:0]  Ez;
  logic [37:0] obs, prev_out = '0;
  logic        rst_q = 1'b1, hold_q = 1'b0;
  int          checks = 0, errors = 0, cyc = 0, idx = 0;
  exp_t        q[$];
  exp_t        x, x2;
  logic [47:0] bm[9] = '{48'h000000400000, 48'h400000000000, 48'h400000000000, 48'h800000000001,
                         48'h7FFFFFFFFFFF, 48'h800000000000, 48'h000000000001, 48'h400000000000,
                         48'h000000000001};
  int          be[9] = '{10, -23, -24, -1, -300, 511, 47, 0, 46};
  logic [47:0] pm[8];
  int          pe[8];

  fp_normalize dut (
    .CLK(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .M_in(M_in), .E_in(E_in),
    .S_in(S_in), .out_valid(out_valid), .out_ready(out_ready), .After_norm(After_norm), .T(T),
    .Sz(Sz), .Ez(Ez), .exp_ovf(exp_ovf), .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_q <= RST;
  end
  assign obs = {After_norm, T, Sz, Ez, exp_ovf, underflow};

  function automatic logic [37:0] pk(exp_t e);
    return {e.an, e.t, e.s, e.ez, e.ovf, e.uf};
  endfunction

  function automatic exp_t mk(logic [24:0] an, logic t, logic [8:0] ez, logic ovf, logic uf,
                              logic s, bit lat);
    exp_t r;
    r.an = an; r.t = t; r.ez = ez; r.ovf = ovf; r.uf = uf; r.s = s; r.cyc = 0; r.lat = lat;
    return r;
  endfunction

  // Value-level reference: place the top bit, then align to either the normal or the subnormal grid.
  function automatic exp_t model(logic [47:0] m, int e, logic s);
    exp_t r;
    logic [95:0] w;
    int p, en, sh;
    r = mk('0, 1'b0, '0, 1'b0, 1'b0, s, 1'b0);
    if (m != '0) begin
      p = 0;
      for (int i = 0; i < 48; i++) if (m[i]) p = i;
      en = e + p - 46;
      sh = (en >= 1) ? 46 - p : e - 1;
      if (sh < -48) sh = -48;
      w = {m, 48'd0};
      w = (sh >= 0) ? (w << sh) : (w >> (-sh));
      r.an = w[94:70];
      r.t = |w[69:0];
      r.ez = (en >= 1) ? 9'(en) : 9'd0;
      r.ovf = (en >= 255);
      r.uf = (en < 1);
`ifndef FP_NORM_SUBNORMAL_EN
      if (r.uf) begin
        r.an = '0;
        r.t = 1'b0;
      end
`endif
    end
    return r;
  endfunction

  task automatic send(input logic [47:0] m, input int e, input logic s, input exp_t xe);
    exp_t y;
    bit done;
    y = xe;
    done = 1'b0;
    in_valid = 1'b1; M_in = m; E_in = 10'(e); S_in = s;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        y.cyc = cyc + 3;
        q.push_back(y);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    checks++;
    assert (done) else begin errors++; $error("FAIL send_timeout got accepted=%0d exp 1", done); end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 100 && q.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    assert (q.size() == 0) else begin errors++; $error("FAIL drain got %0d pending exp 0", q.size()); end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b0) begin
      checks++;
      assert (in_ready === 1'b0) else begin errors++; $error("FAIL stall_in_ready got %b exp 0", in_ready); end
    end
    if (hold_q && !rst_q) begin
      checks++;
      assert ({out_valid, obs} === {1'b1, prev_out}) else begin
        errors++; $error("FAIL stall_hold got %b_%h exp 1_%h", out_valid, obs, prev_out);
      end
    end
    hold_q = (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_out = obs;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (q.size() > 0) else begin errors++; $error("FAIL extra_word got %h exp none", obs); end
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        assert (obs === pk(x)) else begin errors++; $error("FAIL out_word got %h exp %h", obs, pk(x)); end
        if (x.lat) begin
          checks++;
          assert (cyc === x.cyc) else begin errors++; $error("FAIL latency got cyc %0d exp %0d", cyc, x.cyc); end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    checks++;
    assert (out_valid === 1'b0) else begin errors++; $error("FAIL reset_valid got %b exp 0", out_valid); end
    checks++;
    assert (obs === '0) else begin errors++; $error("FAIL reset_outputs got %h exp 0", obs); end
    checks++;
    assert (in_ready === 1'b1) else begin errors++; $error("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    send(48'h800000000000, 127, 1'b0, mk(25'h1000000, 1'b0, 9'd128, 1'b0, 1'b0, 1'b0, 1'b1));
    drain();
    send(48'h400000000001, 127, 1'b1, mk(25'h1000000, 1'b1, 9'd127, 1'b0, 1'b0, 1'b1, 1'b0));
    send(48'h000000400000, 100, 1'b0, mk(25'h1000000, 1'b0, 9'd76, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef FP_NORM_SUBNORMAL_EN
    send(48'h400000000000, -1, 1'b1, mk(25'h0400000, 1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0));
`else
    send(48'h400000000000, -1, 1'b1, mk(25'h0000000, 1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0));
`endif
    send(48'h0, 50, 1'b1, mk(25'h0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    send(48'h400000000000, 255, 1'b0, mk(25'h1000000, 1'b0, 9'd255, 1'b1, 1'b0, 1'b0, 1'b0));
    send(48'h400000000000, 254, 1'b0, mk(25'h1000000, 1'b0, 9'd254, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 9; i++) send(bm[i], be[i], i[0], model(bm[i], be[i], i[0]));
    for (int i = 0; i < 10; i++) begin
      pm[i % 8] = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 47);
      pe[i % 8] = int'($urandom_range(0, 1023)) - 512;
      send(pm[i % 8], pe[i % 8], i[1], model(pm[i % 8], pe[i % 8], i[1]));
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      pm[i] = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 24);
      pe[i] = int'($urandom_range(0, 300)) - 20;
    end
    idx = 0;
    for (int c = 0; c < 60 && (idx < 8 || q.size() > 0); c++) begin
      out_ready = (c < 4 || c > 7);
      in_valid = (idx < 8);
      if (idx < 8) begin
        M_in = pm[idx]; E_in = 10'(pe[idx]); S_in = idx[0];
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        x2 = model(pm[idx], pe[idx], idx[0]);
        q.push_back(x2);
        idx++;
      end
      @(posedge clk); #1;
    end
    checks++;
    assert (idx == 8) else begin errors++; $error("FAIL bp_sent got %0d exp 8", idx); end
    out_ready = 1'b1;
    drain();
    out_ready = 1'b0;
    send(48'h400000000000, 130, 1'b1, mk(25'h1000000, 1'b0, 9'd130, 1'b0, 1'b0, 1'b1, 1'b0));
    send(48'h800000000000, 130, 1'b1, mk(25'h1000000, 1'b0, 9'd131, 1'b0, 1'b0, 1'b1, 1'b0));
    send(48'h000000000001, 130, 1'b1, mk(25'h1000000, 1'b0, 9'd84, 1'b0, 1'b0, 1'b1, 1'b0));
    in_valid = 1'b0;
    RST = 1'b1;
    @(posedge clk); #1;
    RST = 1'b0;
    q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    assert (out_valid === 1'b0) else begin errors++; $error("FAIL midrst_valid got %b exp 0", out_valid); end
    checks++;
    assert (obs === '0) else begin errors++; $error("FAIL midrst_outputs got %h exp 0", obs); end
    @(posedge clk); #1;
    send(48'h000000400000, 100, 1'b1, mk(25'h1000000, 1'b0, 9'd76, 1'b0, 1'b0, 1'b1, 1'b1));
    drain();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    assert (q.size() == 0 && out_valid === 1'b0) else begin
      errors++; $error("FAIL final_idle got %0d/%b exp 0/0", q.size(), out_valid);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
